// File: rtl/wb_stage_pkg.sv
// rtl/wb_stage_pkg.sv - shared write-back select codes, load funct3 codes and default widths
package wb_stage_pkg;

    localparam int XLEN_DEF       = 64;
    localparam int REG_ADDR_W_DEF = 5;
    localparam int CNT_W_DEF      = 64;

    localparam logic [63:0] ZERO_DWORD = 64'h0;

    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'b00,
        WB_SEL_LOAD = 2'b01,
        WB_SEL_PC4  = 2'b10,
        WB_SEL_RSV  = 2'b11
    } wb_sel_e;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LD  = 3'b011,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101,
        F3_LWU = 3'b110,
        F3_ILL = 3'b111
    } load_f3_e;

endpackage

// File: rtl/wb_load_align.sv
// rtl/wb_load_align.sv - combinational load-data lane select, sign/zero extension and fault detect
module wb_load_align
    import wb_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] data,
    input  logic [2:0]      off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] value,
    output logic            fault
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] word_v;

    // Lane selects drop the low offset bits a misaligned access would need,
    // so the value is always defined even when fault is raised.
    always_comb begin
        byte_v = data[{off, 3'b000} +: 8];
        half_v = data[{off[2:1], 4'b0000} +: 16];
        word_v = data[{off[2], 5'b00000} +: 32];
        value  = data;
        fault  = 1'b0;
        case (funct3)
            F3_LB:  value = {{(XLEN-8){byte_v[7]}}, byte_v};
            F3_LBU: value = {{(XLEN-8){1'b0}}, byte_v};
            F3_LH: begin
                value = {{(XLEN-16){half_v[15]}}, half_v};
                fault = off[0];
            end
            F3_LHU: begin
                value = {{(XLEN-16){1'b0}}, half_v};
                fault = off[0];
            end
            F3_LW: begin
                value = {{(XLEN-32){word_v[31]}}, word_v};
                fault = (off[1:0] != 2'b00);
            end
            F3_LWU: begin
                value = {{(XLEN-32){1'b0}}, word_v};
                fault = (off[1:0] != 2'b00);
            end
            F3_LD:   fault = (off != 3'b000);
            default: fault = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MEM/WB pipeline register and register-file write-back; WB_FWD_EN adds EX forwarding outputs
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_rd_addr,
    input  logic [1:0]            mem_wb_sel,
    input  logic [2:0]            mem_funct3,
    input  logic [XLEN-1:0]       mem_alu_result,
    input  logic [XLEN-1:0]       mem_pc,
    input  logic [XLEN-1:0]       mem_load_data,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] WriteAddr,
    output logic [XLEN-1:0]       WriteData,
    output logic                  wb_valid,
    output logic                  load_misalign,
    output logic [CNT_W-1:0]      retire_cnt
`ifdef WB_FWD_EN
    ,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_addr,
    output logic [XLEN-1:0]       fwd_data
`endif
);

    logic                  valid_q, valid_d;
    logic                  fresh_q, fresh_d;
    logic                  reg_write_q, reg_write_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    wb_sel_e               wb_sel_q, wb_sel_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [XLEN-1:0]       alu_q, alu_d;
    logic [XLEN-1:0]       pc_q, pc_d;
    logic [XLEN-1:0]       ld_data_q, ld_data_d;
    logic [CNT_W-1:0]      retire_cnt_q, retire_cnt_d;

    logic [XLEN-1:0]       ld_value;
    logic                  ld_fault;
    logic                  fault;
    logic                  first_cycle;
    logic                  writes_rd;

    wb_load_align #(.XLEN(XLEN)) u_load_align (
        .data   (ld_data_q),
        .off    (alu_q[2:0]),
        .funct3 (funct3_q),
        .value  (ld_value),
        .fault  (ld_fault)
    );

    assign fault       = (wb_sel_q == WB_SEL_LOAD) && ld_fault;
    assign first_cycle = valid_q && fresh_q;
    assign writes_rd   = valid_q && reg_write_q && (rd_q != '0) && !fault;

    always_comb begin
        valid_d      = valid_q;
        fresh_d      = fresh_q;
        reg_write_d  = reg_write_q;
        rd_d         = rd_q;
        wb_sel_d     = wb_sel_q;
        funct3_d     = funct3_q;
        alu_d        = alu_q;
        pc_d         = pc_q;
        ld_data_d    = ld_data_q;
        // Retirement belongs to the entry's first cycle, so it counts even if
        // that cycle ends in a stall or flush.
        retire_cnt_d = retire_cnt_q + ((first_cycle && !fault) ? CNT_W'(1) : CNT_W'(0));
        if (flush_i) begin
            valid_d = 1'b0;
            fresh_d = 1'b0;
        end else if (stall_i) begin
            fresh_d = 1'b0;
        end else begin
            valid_d     = mem_valid;
            fresh_d     = mem_valid;
            reg_write_d = mem_reg_write;
            rd_d        = mem_rd_addr;
            wb_sel_d    = wb_sel_e'(mem_wb_sel);
            funct3_d    = mem_funct3;
            alu_d       = mem_alu_result;
            pc_d        = mem_pc;
            ld_data_d   = mem_load_data;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            valid_q      <= 1'b0;
            fresh_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            rd_q         <= '0;
            wb_sel_q     <= WB_SEL_ALU;
            funct3_q     <= '0;
            alu_q        <= '0;
            pc_q         <= '0;
            ld_data_q    <= '0;
            retire_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            fresh_q      <= fresh_d;
            reg_write_q  <= reg_write_d;
            rd_q         <= rd_d;
            wb_sel_q     <= wb_sel_d;
            funct3_q     <= funct3_d;
            alu_q        <= alu_d;
            pc_q         <= pc_d;
            ld_data_q    <= ld_data_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    always_comb begin
        WriteData = ZERO_DWORD[XLEN-1:0];
        if (valid_q) begin
            case (wb_sel_q)
                WB_SEL_LOAD: WriteData = ld_value;
                WB_SEL_PC4:  WriteData = pc_q + XLEN'(4);
                default:     WriteData = alu_q;
            endcase
        end
    end

    assign mem_ready     = !stall_i;
    assign WriteAddr     = valid_q ? rd_q : '0;
    assign RegWrite      = first_cycle && writes_rd;
    assign wb_valid      = valid_q;
    assign load_misalign = first_cycle && fault;
    assign retire_cnt    = retire_cnt_q;

`ifdef WB_FWD_EN
    assign fwd_valid = writes_rd;
    assign fwd_addr  = WriteAddr;
    assign fwd_data  = WriteData;
`endif

endmodule
